// File: rtl/gpa_spi_iface.sv
// gpa_spi_iface: N-channel SPI serialiser for a gradient power amplifier DAC board.
// Broadcasts queue one frame deep behind the active one; a second queued broadcast flags ovf_o.
module gpa_spi_iface #(
    parameter int NCH    = 4,
    parameter int WORD_W = 24,
    parameter int DIV_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_i,
    input  logic             valid_i,
    input  logic [DIV_W-1:0] spi_clk_div_i,
    input  logic             ldac_mode_i,
    output logic             sclk_o,
    output logic             syncn_o,
    output logic             ldacn_o,
    output logic [NCH-1:0]   sdo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);
    localparam int BCW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_LDAC
    } state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] staging [NCH];
    logic [WORD_W-1:0] shreg   [NCH];
    logic              pending, pending_nx;
    logic [DIV_W-1:0]  div_q, div_eff;
    logic [DIV_W-1:0]  div_ctr, div_ctr_nx;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nx;
    logic              load, shift_en, bcast, period_end;
    logic              unused_data;

    assign unused_data = ^data_i;
    assign bcast       = valid_i & data_i[24];
    assign div_eff     = (spi_clk_div_i == '0) ? DIV_W'(1) : spi_clk_div_i;
    assign period_end  = (div_ctr == div_q);

    always_comb begin
        state_nx   = state;
        div_ctr_nx = div_ctr;
        bit_cnt_nx = bit_cnt;
        load       = 1'b0;
        shift_en   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pending) begin
                    load       = 1'b1;
                    div_ctr_nx = '0;
                    bit_cnt_nx = BCW'(WORD_W);
                    state_nx   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (period_end) begin
                    div_ctr_nx = '0;
                    shift_en   = 1'b1;
                    bit_cnt_nx = bit_cnt - BCW'(1);
                    if (bit_cnt == BCW'(1)) state_nx = S_GAP;
                end else begin
                    div_ctr_nx = div_ctr + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (period_end) begin
                    div_ctr_nx = '0;
                    state_nx   = ldac_mode_i ? S_LDAC : S_IDLE;
                end else begin
                    div_ctr_nx = div_ctr + DIV_W'(1);
                end
            end
            S_LDAC: begin
                if (period_end) begin
                    div_ctr_nx = '0;
                    state_nx   = S_IDLE;
                end else begin
                    div_ctr_nx = div_ctr + DIV_W'(1);
                end
            end
        endcase
        // a broadcast landing on the load cycle re-arms the queue
        pending_nx = (pending & ~load) | bcast;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            div_q   <= DIV_W'(1);
            div_ctr <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                staging[i] <= '0;
                shreg[i]   <= '0;
            end
            sclk_o  <= 1'b0;
            syncn_o <= 1'b1;
            ldacn_o <= 1'b1;
            sdo_o   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            div_ctr <= div_ctr_nx;
            bit_cnt <= bit_cnt_nx;
            for (int i = 0; i < NCH; i++) begin
                if (valid_i && int'(data_i[28:25]) == i)
                    staging[i] <= data_i[WORD_W-1:0];
                if (load)
                    shreg[i] <= staging[i];
                else if (shift_en)
                    shreg[i] <= {shreg[i][WORD_W-2:0], 1'b0};
                sdo_o[i] <= shreg[i][WORD_W-1];
            end
            if (load) div_q <= div_eff;
            sclk_o  <= (state == S_SHIFT) && (div_ctr < (div_q >> 1));
            syncn_o <= (state != S_SHIFT);
            ldacn_o <= (state == S_LDAC) ? 1'b0 : ldac_mode_i;
            busy_o  <= (state_nx != S_IDLE) | pending_nx;
            done_o  <= (state != S_IDLE) && (state_nx == S_IDLE);
            if (bcast && pending) ovf_o <= 1'b1;
        end
    end

endmodule
